// File: rtl/hilo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_ctrl_pkg
//  Description : Shared HI/LO operation and sequencer state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package hilo_ctrl_pkg;

    typedef enum logic [2:0] {
        HILO_OP_NONE  = 3'd0,
        HILO_OP_MULT  = 3'd1,
        HILO_OP_MULTU = 3'd2,
        HILO_OP_DIV   = 3'd3,
        HILO_OP_DIVU  = 3'd4,
        HILO_OP_MTHI  = 3'd5,
        HILO_OP_MTLO  = 3'd6
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } hilo_state_e;

endpackage : hilo_ctrl_pkg
`default_nettype wire

// File: rtl/hilo_ctrl_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_ctrl_div_iter
//  Description : Unsigned radix-2 restoring divider, one quotient bit per step.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_ctrl_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_partial;
    logic [WIDTH:0]   w_trial;

    // Partial remainder always stays below the divisor, so WIDTH+1 bits suffice.
    assign w_partial = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_partial - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (start) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_dvs <= divisor;
        end else if (step) begin
            if (!w_trial[WIDTH]) begin
                r_rem <= w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_partial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule : hilo_ctrl_div_iter
`default_nettype wire

// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_ctrl
//  Description : EX-stage HI/LO write sequencer: one-cycle multiply/move ops,
//                multi-cycle iterative divide with pipeline stall.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter bit DIV_ZERO_WRITE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flushE,
    input  logic [WIDTH-1:0] hi_cur_i,
    input  logic [WIDTH-1:0] lo_cur_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    hilo_state_e        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;

    hilo_op_e           w_op;
    logic               w_is_div;
    logic               w_is_signed;
    logic               w_b_zero;
    logic               w_div_start;
    logic               w_div_step;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;

    assign w_op        = hilo_op_e'(op_i);
    assign w_is_div    = (w_op == HILO_OP_DIV) || (w_op == HILO_OP_DIVU);
    assign w_is_signed = (w_op == HILO_OP_DIV);
    assign w_b_zero    = (src_b_i == '0);
    assign w_div_start = (r_state == ST_IDLE) && op_valid_i && !flushE
                         && w_is_div && !w_b_zero;
    assign w_div_step  = (r_state == ST_BUSY) && !flushE;

    // Two's-complement negation of the most negative value yields its magnitude unsigned.
    assign w_abs_a = (w_is_signed && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
    assign w_abs_b = (w_is_signed && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    assign w_prod_s = {{WIDTH{src_a_i[WIDTH-1]}}, src_a_i} * {{WIDTH{src_b_i[WIDTH-1]}}, src_b_i};
    assign w_prod_u = {{WIDTH{1'b0}}, src_a_i} * {{WIDTH{1'b0}}, src_b_i};

    hilo_ctrl_div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .step      (w_div_step),
        .dividend  (w_abs_a),
        .divisor   (w_abs_b),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
    assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_div_start) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= '0;
                        r_neg_q <= w_is_signed && (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
                        r_neg_r <= w_is_signed && src_a_i[WIDTH-1];
                    end
                end
                ST_BUSY: begin
                    if (flushE) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                        if (r_cnt == C_CNT_LAST) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (r_state != ST_IDLE);

    always_comb begin
        stall_o   = 1'b0;
        hilo_we_o = 1'b0;
        hi_o      = '0;
        lo_o      = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (op_valid_i) begin
                    case (w_op)
                        HILO_OP_MULT: begin
                            hilo_we_o    = 1'b1;
                            {hi_o, lo_o} = w_prod_s;
                        end
                        HILO_OP_MULTU: begin
                            hilo_we_o    = 1'b1;
                            {hi_o, lo_o} = w_prod_u;
                        end
                        HILO_OP_MTHI: begin
                            hilo_we_o = 1'b1;
                            hi_o      = src_a_i;
                            lo_o      = lo_cur_i;
                        end
                        HILO_OP_MTLO: begin
                            hilo_we_o = 1'b1;
                            hi_o      = hi_cur_i;
                            lo_o      = src_a_i;
                        end
                        HILO_OP_DIV, HILO_OP_DIVU: begin
                            if (!w_b_zero) begin
                                stall_o = 1'b1;
                            end else if (DIV_ZERO_WRITE) begin
                                hilo_we_o = 1'b1;
                                hi_o      = src_a_i;
                                lo_o      = '1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_BUSY: stall_o = 1'b1;
            ST_DONE: begin
                hilo_we_o = 1'b1;
                hi_o      = w_rem_fix;
                lo_o      = w_quo_fix;
            end
            default: ;
        endcase
        if (!rst || flushE) begin
            stall_o   = 1'b0;
            hilo_we_o = 1'b0;
        end
    end

endmodule : hilo_ctrl
`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_ctrl
//  Description : Directed vector bench for the HI/LO write sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_ctrl;

    localparam int WIDTH = 32;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic             clk;
    logic             rst;
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic [WIDTH-1:0] hi_cur;
    logic [WIDTH-1:0] lo_cur;
    logic             stall;
    logic             busy;
    logic             we;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        flush;
        logic [31:0] hic;
        logic [31:0] loc;
        logic        e_stall;
        logic        e_we;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    hilo_ctrl #(
        .WIDTH          (WIDTH),
        .DIV_ZERO_WRITE (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid_i (op_valid),
        .op_i       (op),
        .src_a_i    (src_a),
        .src_b_i    (src_b),
        .flushE     (flush),
        .hi_cur_i   (hi_cur),
        .lo_cur_i   (lo_cur),
        .stall_o    (stall),
        .busy_o     (busy),
        .hilo_we_o  (we),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = v;
        op       = o;
        src_a    = a;
        src_b    = b;
    endtask

    // Expects the divide to be presented before the negedge of its accept cycle.
    task automatic wait_div(input string name, input logic [31:0] e_hi, input logic [31:0] e_lo);
        int n;
        n = 0;
        @(negedge clk);
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, " stall_cycles"}, 64'(n), 64'd33);
        check({name, " done_we"}, 64'(we), 64'd1);
        check({name, " done_busy"}, 64'(busy), 64'd1);
        check({name, " hi"}, 64'(hi), 64'(e_hi));
        check({name, " lo"}, 64'(lo), 64'(e_lo));
    endtask

    task automatic do_div(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo);
        @(posedge clk); #1;
        drive(1'b1, o, a, b);
        wait_div(name, e_hi, e_lo);
        @(posedge clk); #1;
        drive(1'b0, OP_NONE, '0, '0);
        @(negedge clk);
        check({name, " idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, OP_MULT,  32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, OP_NONE,  32'h1234_5678, 32'h0000_0003, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[2]  = '{1'b1, OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[3]  = '{1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4]  = '{1'b1, OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4000_0000, 32'h0000_0000};
        vecs[5]  = '{1'b1, OP_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001};
        vecs[6]  = '{1'b1, OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA};
        vecs[7]  = '{1'b1, OP_MTHI,  32'hCAFE_F00D, 32'h0,         1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h2222_2222};
        vecs[8]  = '{1'b1, OP_MTLO,  32'hDEAD_BEEF, 32'h0,         1'b0, 32'h3333_3333, 32'h4444_4444, 1'b0, 1'b1, 32'h3333_3333, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, OP_DIV,   32'h0000_0064, 32'h0,         1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[10] = '{1'b1, OP_MULT,  32'h0000_0005, 32'h0000_0006, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, OP_DIVU,  32'h0000_0064, 32'h0000_0007, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};

        rst    = 1'b0;
        flush  = 1'b0;
        hi_cur = '0;
        lo_cur = '0;
        drive(1'b1, OP_MULT, 32'd2, 32'd3);

        @(negedge clk);
        @(negedge clk);
        check("reset stall", 64'(stall), 64'd0);
        check("reset we", 64'(we), 64'd0);
        check("reset busy", 64'(busy), 64'd0);

        @(posedge clk); #1;
        drive(1'b0, OP_NONE, '0, '0);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].valid, vecs[i].op, vecs[i].a, vecs[i].b);
            flush  = vecs[i].flush;
            hi_cur = vecs[i].hic;
            lo_cur = vecs[i].loc;
            @(negedge clk);
            check($sformatf("vec%0d stall", i), 64'(stall), 64'(vecs[i].e_stall));
            check($sformatf("vec%0d we", i), 64'(we), 64'(vecs[i].e_we));
            check($sformatf("vec%0d busy", i), 64'(busy), 64'd0);
            if (vecs[i].e_we) begin
                check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].e_hi));
                check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].e_lo));
            end
        end
        @(posedge clk); #1;
        drive(1'b0, OP_NONE, '0, '0);
        flush = 1'b0;
        @(negedge clk);
        check("post-vector busy", 64'(busy), 64'd0);

        do_div("divu 100/7",    OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14);
        do_div("div -7/2",      OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_div("div 7/-2",      OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        do_div("div min/-1",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
        do_div("divu max/1",    OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF);
        do_div("divu 5/9",      OP_DIVU, 32'd5,         32'd9,         32'd5,         32'd0);

        // Flush during the eleventh BUSY cycle, then a move into LO.
        @(posedge clk); #1;
        drive(1'b1, OP_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        check("flush accept stall", 64'(stall), 64'd1);
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush stall", 64'(stall), 64'd0);
        check("flush we", 64'(we), 64'd0);
        check("flush busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        drive(1'b0, OP_NONE, '0, '0);
        @(negedge clk);
        check("flush idle busy", 64'(busy), 64'd0);
        check("flush idle we", 64'(we), 64'd0);
        @(posedge clk); #1;
        hi_cur = 32'hAAAA_5555;
        lo_cur = 32'h0F0F_0F0F;
        drive(1'b1, OP_MTLO, 32'h0000_1234, '0);
        @(negedge clk);
        check("mtlo we", 64'(we), 64'd1);
        check("mtlo hi", 64'(hi), 64'(32'hAAAA_5555));
        check("mtlo lo", 64'(lo), 64'(32'h0000_1234));
        check("mtlo stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        drive(1'b0, OP_NONE, '0, '0);

        // Asynchronous reset during BUSY step 20, op still held by the pipeline.
        @(posedge clk); #1;
        drive(1'b1, OP_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        check("rst accept stall", 64'(stall), 64'd1);
        repeat (21) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst mid stall", 64'(stall), 64'd0);
        check("rst mid we", 64'(we), 64'd0);
        check("rst mid busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("rst hold stall", 64'(stall), 64'd0);
        check("rst hold busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_div("divu restart", 32'd2, 32'd14);
        @(posedge clk); #1;
        drive(1'b0, OP_NONE, '0, '0);
        @(negedge clk);
        check("restart idle busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hilo_ctrl
`default_nettype wire
